// File: rtl/dsr_stim_checker.sv
// Self-test sequencer for a set/reset D flip-flop cell.
// Runs 16 stimulus steps and checks Q/notQ against an ideal model.
module dsr_stim_checker (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_q,
    input  logic       dut_notq,
    output logic       dut_d,
    output logic       dut_s,
    output logic       dut_r,
    output logic       dut_clk,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [3:0] fail_step
);

    typedef enum logic [2:0] {
        IDLE, SETUP, CLKH, CLKL, CHECK, DONE
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] step, step_nxt;
    logic [3:0] err_nxt, fail_nxt;
    logic       pass_nxt;
    logic       vr, vs, vd, exp_q, checked, mismatch;
    logic       d_nxt, s_nxt, r_nxt, clk_nxt, busy_nxt, done_nxt;

    // Step vector decode and ideal-model comparison
    always_comb begin
        vr       = step[2];
        vs       = step[1];
        vd       = step[0];
        checked  = ~(vr & vs);
        exp_q    = vs | (~vr & vd);
        mismatch = checked &&
                   ((dut_q != exp_q) || (dut_notq != ~exp_q));
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= 4'd0;
            err_count <= 4'd0;
            fail_step <= 4'd0;
            pass      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dut_d     <= 1'b0;
            dut_s     <= 1'b0;
            dut_r     <= 1'b0;
            dut_clk   <= 1'b0;
        end else begin
            state     <= state_nxt;
            step      <= step_nxt;
            err_count <= err_nxt;
            fail_step <= fail_nxt;
            pass      <= pass_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            dut_d     <= d_nxt;
            dut_s     <= s_nxt;
            dut_r     <= r_nxt;
            dut_clk   <= clk_nxt;
        end
    end

    // Next state and result bookkeeping
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        err_nxt   = err_count;
        fail_nxt  = fail_step;
        pass_nxt  = pass;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SETUP;
                    step_nxt  = 4'd0;
                    err_nxt   = 4'd0;
                    fail_nxt  = 4'd0;
                    pass_nxt  = 1'b0;
                end
            end
            SETUP: state_nxt = CLKH;
            CLKH:  state_nxt = CLKL;
            CLKL:  state_nxt = CHECK;
            CHECK: begin
                if (mismatch) begin
                    err_nxt = err_count + 4'd1;
                    if (err_count == 4'd0)
                        fail_nxt = step;
                end
                if (step == 4'd15) begin
                    state_nxt = DONE;
                    pass_nxt  = (err_nxt == 4'd0);
                end else begin
                    state_nxt = SETUP;
                    step_nxt  = step + 4'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output values for the upcoming state, registered above
    always_comb begin
        busy_nxt = (state_nxt == SETUP) || (state_nxt == CLKH) ||
                   (state_nxt == CLKL)  || (state_nxt == CHECK);
        done_nxt = (state_nxt == DONE);
        clk_nxt  = (state_nxt == CLKH);
        d_nxt    = 1'b0;
        s_nxt    = 1'b0;
        r_nxt    = 1'b0;
        if (busy_nxt) begin
            d_nxt = step_nxt[0];
            s_nxt = step_nxt[1];
            r_nxt = step_nxt[2];
        end
    end

endmodule

// File: tb/tb_dsr_stim_checker.sv
// Scoreboard bench for dsr_stim_checker with a fault-injectable
// ideal dffsr cell model on the far side.
module tb_dsr_stim_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       dut_q, dut_notq;
    logic       dut_d, dut_s, dut_r, dut_clk;
    logic       busy, done, pass;
    logic [3:0] err_count, fail_step;

    typedef struct {
        int err;
        int fail;
        int pass;
    } res_t;

    res_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mode    = 0;
    logic mq      = 1'b0;

    dsr_stim_checker u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dut_q     (dut_q),
        .dut_notq  (dut_notq),
        .dut_d     (dut_d),
        .dut_s     (dut_s),
        .dut_r     (dut_r),
        .dut_clk   (dut_clk),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_step (fail_step)
    );

    always #5 clk = ~clk;

    // Ideal cell; reset wins over set
    always @(posedge dut_clk) begin
        if (dut_r)      mq <= 1'b0;
        else if (dut_s) mq <= 1'b1;
        else            mq <= dut_d;
    end

    // Fault modes: 0 ideal, 1 Q stuck 0, 2 Q stuck 1, 3 notQ=Q
    always_comb begin
        case (mode)
            1:       begin dut_q = 1'b0; dut_notq = 1'b1; end
            2:       begin dut_q = 1'b1; dut_notq = 1'b0; end
            3:       begin dut_q = mq;   dut_notq = mq;   end
            default: begin dut_q = mq;   dut_notq = ~mq;  end
        endcase
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic res_t model(input int m);
        res_t       r;
        logic [3:0] v;
        logic       e, q, nq;
        r.err  = 0;
        r.fail = 0;
        for (int i = 0; i < 16; i++) begin
            v = i[3:0];
            if (!(v[2] && v[1])) begin
                e = v[1] ? 1'b1 : (v[2] ? 1'b0 : v[0]);
                case (m)
                    1:       begin q = 1'b0; nq = 1'b1; end
                    2:       begin q = 1'b1; nq = 1'b0; end
                    3:       begin q = e;    nq = e;    end
                    default: begin q = e;    nq = ~e;   end
                endcase
                if (q != e || nq != ~e) begin
                    if (r.err == 0) r.fail = i;
                    r.err++;
                end
            end
        end
        r.pass = (r.err == 0);
        return r;
    endfunction

    function automatic int outs();
        return {busy, done, pass, err_count, fail_step,
                dut_d, dut_s, dut_r, dut_clk};
    endfunction

    task automatic run(input string nm, input int m,
                       input int extra_start, input int rst_at);
        int   cyc, busy_cnt, vec_err, st, ph;
        bit   got_done;
        res_t e;
        logic [3:0] sv;
        mode = m;
        @(negedge clk);
        start = 1'b1;
        if (rst_at < 0) sb.push_back(model(m));
        @(negedge clk);
        start    = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        vec_err  = 0;
        got_done = 0;
        while (cyc <= 200 && !got_done) begin
            if (done) begin
                got_done = 1;
            end else begin
                if (busy) busy_cnt++;
                st = (cyc - 1) / 4;
                ph = (cyc - 1) % 4;
                sv = st[3:0];
                if (cyc > 64 ||
                    {busy, dut_r, dut_s, dut_d, dut_clk} !=
                    {1'b1, sv[2:0], ph == 1})
                    vec_err++;
                start = (cyc == extra_start);
                if (cyc == rst_at) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    chk({nm, "_rst_outs"}, outs(), 0);
                    chk({nm, "_rst_vec"}, vec_err, 0);
                    @(negedge clk);
                    chk({nm, "_rst_idle"}, busy, 0);
                    return;
                end
                @(negedge clk);
                cyc++;
            end
        end
        chk({nm, "_done_seen"}, got_done, 1);
        if (got_done) begin
            chk({nm, "_latency"}, cyc, 65);
            chk({nm, "_busy_cycles"}, busy_cnt, 64);
            chk({nm, "_vectors"}, vec_err, 0);
            chk({nm, "_done_outs"},
                {busy, dut_d, dut_s, dut_r, dut_clk}, 0);
            if (sb.size() == 0) begin
                chk({nm, "_sb_empty"}, 1, 0);
            end else begin
                e = sb.pop_front();
                chk({nm, "_err_count"}, err_count, e.err);
                chk({nm, "_fail_step"}, fail_step, e.fail);
                chk({nm, "_pass"}, pass, e.pass);
            end
            @(negedge clk);
            chk({nm, "_done_pulse"}, done, 0);
            chk({nm, "_pass_held"}, pass, e.pass);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outs", outs(), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outs", outs(), 0);

        run("ideal", 0, -1, -1);
        run("stuck0", 1, -1, -1);
        run("stuck1", 2, -1, -1);
        run("notq_eq_q", 3, -1, -1);
        run("late_start", 0, 13, -1);
        run("mid_rst", 1, -1, 24);

        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_beats_start", busy, 0);

        run("after_rst", 0, -1, -1);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
